prog_launch_bridge: RTL and testbench
=====================================

Name: prog_launch_bridge

Overview:
- Host-side (labkit) controller for the processor's program-select / result interface; it is the other end of the regfile's program_selector input and data output.
- On a start request it drives a program number onto program_selector as a timed pulse.
- It then watches the core's data output until the value stays unchanged for a set number of cycles, and latches that value as the result.
- Sits between the labkit switches/buttons/display logic and the processor core.

Parameters:
- DW, 32, width of program_selector, core_data and result.
- SEL_CYCLES, 2, cycles program_selector is held non-zero (range 1..255).
- STABLE_CYCLES, 8, consecutive unchanged core_data cycles that count as done (range 1..65535).
- TIMEOUT_CYCLES, 4096, maximum cycles spent in WAIT before abort (must be greater than STABLE_CYCLES).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
- start  in  1  launch request, level input; the rising edge is detected internally.
- prog_id  in  DW  program number to launch; 0 is illegal.
- core_data  in  DW  regfile data output from the core.
- program_selector  out  DW  registered; drives the regfile program-select input.
- result  out  DW  registered captured result.
- result_valid  out  1  high in DONE after a stable capture.
- busy  out  1  high in ASSERT and WAIT.
- timed_out  out  1  high in DONE after a timeout.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; program_selector=0, result=0; result_valid, busy, timed_out =0.
  - All counters=0; start_q=0.
  - Applies mid-operation too: program_selector returns to 0 at the next edge.
- start_q is a registered copy of start. A rising edge is start & !start_q.
- FSM states: IDLE, ASSERT, WAIT, DONE.
- IDLE:
  - On a rising edge with prog_id!=0: latch prog_id into program_selector, sel_cnt=0, go to ASSERT.
  - On a rising edge with prog_id==0: ignored; stay in IDLE, outputs unchanged.
- ASSERT:
  - busy=1; program_selector is held for exactly SEL_CYCLES cycles.
  - When sel_cnt==SEL_CYCLES-1: program_selector becomes 0 at that edge; load prev_data=core_data, stab_cnt=0, to_cnt=0; go to WAIT.
- WAIT:
  - busy=1. Each cycle to_cnt increments.
  - If core_data==prev_data, stab_cnt increments; otherwise stab_cnt=0. prev_data takes core_data every cycle.
  - Stable: when stab_cnt reaches STABLE_CYCLES-1 and the current sample is equal, set result=core_data, result_valid=1 and go to DONE.
  - Timeout: when to_cnt reaches TIMEOUT_CYCLES-1, set result=core_data, timed_out=1, result_valid=0 and go to DONE.
  - If stable and timeout occur in the same cycle, stable wins: result_valid=1, timed_out=0.
- DONE:
  - busy=0; result and the flags are held.
  - Returns to IDLE only once start==0. On that edge result_valid and timed_out clear; result is retained.
- start edges while in ASSERT or WAIT are ignored and not queued.
- A start held high through DONE causes no relaunch; a new rising edge is required.
- Latency, start edge to program_selector non-zero: 1 cycle after start is sampled.
- Minimum latency, start edge to result_valid: 1+SEL_CYCLES+STABLE_CYCLES cycles.
- Counters saturate and never wrap; their widths are sized from the parameters.

Optional Feature:
- Macro: PROG_LAUNCH_RUN_COUNT_EN.
- When defined:
  - Adds output run_cycles, 32 bits.
  - Clears to 0 on reset and on leaving IDLE.
  - Increments every cycle in ASSERT and WAIT, saturating at 0xFFFFFFFF.
  - Frozen in DONE.
- When not defined: the port and its counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package plb_pkg holds:
  - the state enum: IDLE=2'd0, ASSERT=2'd1, WAIT=2'd2, DONE=2'd3;
  - default parameter constants;
  - a clog2-based counter-width helper.
- One natural sub-module, stability_detector:
  - contains prev_data, stab_cnt and the equality compare;
  - inputs: clear, sample enable, data;
  - output: a stable pulse.

Test Plan:
- Basic launch: prog_id=1, start pulse, core_data fixed at 0x2A from the edge onward -> program_selector=1 for 2 cycles then 0; result=0x2A with result_valid=1 at cycle 1+2+8 after start is sampled.
- Changing data: core_data steps 5,6,7 then holds 9 -> the stability count restarts on each change; result=9 is valid 8 cycles after 9 first appears.
- Timeout: TIMEOUT_CYCLES=64, core_data toggles every cycle -> timed_out=1, result_valid=0, DONE reached 64 cycles after WAIT entry.
- Illegal and ignored starts: start with prog_id=0 -> stays IDLE, program_selector=0; a second start edge during WAIT -> no relaunch; start held high in DONE -> stays in DONE until start=0.
- Reset mid-op: reset=0 for one cycle in ASSERT -> program_selector=0, state IDLE, all flags 0 at the next edge.
- With PROG_LAUNCH_RUN_COUNT_EN: the basic launch case gives run_cycles=10, frozen in DONE.

Source files
------------

// File: rtl/prog_launch_bridge_pkg.sv
// plb_pkg: shared definitions for prog_launch_bridge.
//   - plb_state_e : launch FSM state encoding
//   - PLB_*       : default parameter values
//   - cnt_width() : bit width needed for a counter that spans 0..n-1
package plb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } plb_state_e;

   localparam int unsigned PLB_DW             = 32;
   localparam int unsigned PLB_SEL_CYCLES     = 2;
   localparam int unsigned PLB_STABLE_CYCLES  = 8;
   localparam int unsigned PLB_TIMEOUT_CYCLES = 4096;

   // Counter must hold values 0..max_count-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count <= 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/prog_launch_bridge_if.sv
// prog_launch_bridge_if: labkit <-> processor launch/result bundle.
//   master modport : labkit side (drives start/prog_id, sees results)
//                    core_data is also driven from this side of the bundle
//   slave modport  : prog_launch_bridge
//   Signals: start, prog_id, core_data, program_selector, result,
//            result_valid, busy, timed_out
interface prog_launch_bridge_if
   import plb_pkg::*;
#(
   parameter int unsigned DW = PLB_DW
);

   logic          start;
   logic [DW-1:0] prog_id;
   logic [DW-1:0] core_data;
   logic [DW-1:0] program_selector;
   logic [DW-1:0] result;
   logic          result_valid;
   logic          busy;
   logic          timed_out;

   modport master (
      output start, prog_id, core_data,
      input  program_selector, result, result_valid, busy, timed_out
   );

   modport slave (
      input  start, prog_id, core_data,
      output program_selector, result, result_valid, busy, timed_out
   );

endinterface

// File: rtl/prog_launch_bridge_stability_detector.sv
// stability_detector: counts consecutive cycles in which data repeats.
//   clock, reset : clock; synchronous active-low reset
//   clear        : reload prev_data from data and zero the run count
//   sample_en    : compare data against prev_data this cycle
//   data         : monitored word
//   stable       : one-cycle pulse when the current sample completes a run
//                  of STABLE_CYCLES equal comparisons
module stability_detector
   import plb_pkg::*;
#(
   parameter int unsigned DW            = PLB_DW,
   parameter int unsigned STABLE_CYCLES = PLB_STABLE_CYCLES
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          sample_en,
   input  logic [DW-1:0] data,
   output logic          stable
);

   localparam int unsigned SW = cnt_width(STABLE_CYCLES);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

   logic [DW-1:0] prev_data;
   logic [SW-1:0] stab_cnt;
   logic          same;

   assign same   = (data == prev_data);
   assign stable = sample_en && !clear && same && (stab_cnt == STAB_LAST);

   always_ff @(posedge clock) begin
      if (!reset) begin
         prev_data <= '0;
         stab_cnt  <= '0;
      end else if (clear) begin
         prev_data <= data;
         stab_cnt  <= '0;
      end else if (sample_en) begin
         prev_data <= data;
         if (!same)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_LAST)
            stab_cnt <= stab_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/prog_launch_bridge.sv
// prog_launch_bridge: host-side launcher for the core's program-select input.
// A rising edge on start (with prog_id != 0) drives prog_id onto
// program_selector for SEL_CYCLES cycles, then watches core_data until it
// stays unchanged for STABLE_CYCLES comparisons (result_valid) or until
// TIMEOUT_CYCLES cycles pass in WAIT (timed_out). DONE is left once start=0.
//   clock, reset : clock; synchronous active-low reset
//   bus (slave)  : start, prog_id, core_data in;
//                  program_selector, result, result_valid, busy, timed_out out
//   run_cycles   : cycles spent in ASSERT+WAIT for the last launch; present
//                  only when PROG_LAUNCH_RUN_COUNT_EN is defined
module prog_launch_bridge
   import plb_pkg::*;
#(
   parameter int unsigned DW             = PLB_DW,
   parameter int unsigned SEL_CYCLES     = PLB_SEL_CYCLES,
   parameter int unsigned STABLE_CYCLES  = PLB_STABLE_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = PLB_TIMEOUT_CYCLES
) (
   input logic                clock,
   input logic                reset,
   prog_launch_bridge_if.slave bus
`ifdef PROG_LAUNCH_RUN_COUNT_EN
   ,
   output logic [31:0]        run_cycles
`endif
);

   localparam int unsigned SEL_W = cnt_width(SEL_CYCLES);
   localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEL_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   plb_state_e    state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [DW-1:0] psel_q, psel_d;
   logic [DW-1:0] result_q, result_d;
   logic          valid_q, valid_d;
   logic          tmo_q, tmo_d;
   logic          start_q;
   logic          start_rise;
   logic          det_clear;
   logic          det_en;
   logic          det_stable;

   assign start_rise = bus.start && !start_q;

   // Detector control depends only on registered state, keeping the
   // stable -> next-state path free of combinational feedback.
   assign det_clear = (state_q == ASSERT) && (sel_q == SEL_LAST);
   assign det_en    = (state_q == WAIT);

   stability_detector #(
      .DW            (DW),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_stab (
      .clock     (clock),
      .reset     (reset),
      .clear     (det_clear),
      .sample_en (det_en),
      .data      (bus.core_data),
      .stable    (det_stable)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      to_d     = to_q;
      psel_d   = psel_q;
      result_d = result_q;
      valid_d  = valid_q;
      tmo_d    = tmo_q;
      case (state_q)
         IDLE: begin
            if (start_rise && (bus.prog_id != '0)) begin
               psel_d  = bus.prog_id;
               sel_d   = '0;
               state_d = ASSERT;
            end
         end
         ASSERT: begin
            if (sel_q == SEL_LAST) begin
               psel_d  = '0;
               to_d    = '0;
               state_d = WAIT;
            end else begin
               sel_d = sel_q + 1'b1;
            end
         end
         WAIT: begin
            if (to_q != TO_LAST)
               to_d = to_q + 1'b1;
            // Stable is tested first so it wins a same-cycle timeout.
            if (det_stable) begin
               result_d = bus.core_data;
               valid_d  = 1'b1;
               tmo_d    = 1'b0;
               state_d  = DONE;
            end else if (to_q == TO_LAST) begin
               result_d = bus.core_data;
               valid_d  = 1'b0;
               tmo_d    = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (!bus.start) begin
               valid_d = 1'b0;
               tmo_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         to_q     <= '0;
         psel_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         tmo_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         to_q     <= to_d;
         psel_q   <= psel_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         tmo_q    <= tmo_d;
         start_q  <= bus.start;
      end
   end

   assign bus.program_selector = psel_q;
   assign bus.result           = result_q;
   assign bus.result_valid     = valid_q;
   assign bus.timed_out        = tmo_q;
   assign bus.busy             = (state_q == ASSERT) || (state_q == WAIT);

`ifdef PROG_LAUNCH_RUN_COUNT_EN
   logic [31:0] run_q, run_d;

   always_comb begin
      run_d = run_q;
      if ((state_q == IDLE) && (state_d != IDLE))
         run_d = '0;
      else if (((state_q == ASSERT) || (state_q == WAIT)) && (run_q != '1))
         run_d = run_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset)
         run_q <= '0;
      else
         run_q <= run_d;
   end

   assign run_cycles = run_q;
`endif

endmodule

// File: tb/tb_prog_launch_bridge.sv
// Self-checking bench for prog_launch_bridge (SEL=2, STABLE=8, TIMEOUT=64).
// Edge 0 is the clock edge that samples the start rise; core_data for each
// launch is a function of the edge index so expected completion edges can be
// written down directly.
module tb_prog_launch_bridge;

   localparam int unsigned SEL  = 2;
   localparam int unsigned STB  = 8;
   localparam int unsigned TMO  = 64;
   localparam int          MAXN = 200;

   localparam int K_CONST  = 0;
   localparam int K_STEPS  = 1;
   localparam int K_TOGGLE = 2;
   localparam int K_HOLD   = 3;
   localparam int K_RAND   = 4;

   typedef struct {
      logic [31:0] prog;
      int          kind;
      logic [31:0] v;
      int          restart_at;
      bit          hold_start;
      int          exp_done;
      logic [31:0] exp_result;
      bit          exp_valid;
      bit          exp_tmo;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   prog_launch_bridge_if #(.DW(32)) bus();

`ifdef PROG_LAUNCH_RUN_COUNT_EN
   logic [31:0] run_cycles;
`endif

   prog_launch_bridge #(
      .DW             (32),
      .SEL_CYCLES     (SEL),
      .STABLE_CYCLES  (STB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus)
`ifdef PROG_LAUNCH_RUN_COUNT_EN
      ,
      .run_cycles (run_cycles)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] rnd_data [0:MAXN];
   vec_t tbl [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] data_at(input int kind, input int n, input logic [31:0] v);
      logic [31:0] tog;
      tog = n[0] ? 32'hA5 : 32'h5A;
      case (kind)
         K_CONST:  return v;
         K_STEPS:  return (n <= 3) ? 32'd5 : (n == 4) ? 32'd6 : (n == 5) ? 32'd7 : 32'd9;
         K_TOGGLE: return tog;
         K_HOLD:   return (n >= int'(v)) ? 32'h77 : tog;
         default:  return rnd_data[n];
      endcase
   endfunction

   // Reference: WAIT starts at edge SEL with sample s[0]; at WAIT step j
   // (edge SEL+j) the launch finishes stable if the last STB+1 samples are all
   // equal, otherwise it times out when j reaches TMO.
   task automatic model(input int kind, input logic [31:0] v, output int done,
                        output logic [31:0] res, output bit vld, output bit tmo);
      done = -1; res = '0; vld = 1'b0; tmo = 1'b0;
      for (int j = 1; j <= int'(TMO); j++) begin
         bit same;
         same = (j >= int'(STB));
         for (int i = j - int'(STB); same && i < j; i++)
            if (data_at(kind, int'(SEL) + i, v) != data_at(kind, int'(SEL) + j, v))
               same = 1'b0;
         if (same || j == int'(TMO)) begin
            done = int'(SEL) + j;
            res  = data_at(kind, int'(SEL) + j, v);
            vld  = same;
            tmo  = !same;
            return;
         end
      end
   endtask

   task automatic run_case(input vec_t c, input string tag);
      int done_seen;
      int e;
      done_seen = -1;
      @(negedge clock);
      bus.prog_id   = c.prog;
      bus.start     = 1'b1;
      bus.core_data = data_at(c.kind, 0, c.v);
      for (int n = 1; n <= MAXN && done_seen < 0; n++) begin
         @(negedge clock);
         e = n - 1;
         if (e == 0) begin
            check({tag, "_sel_e0"}, bus.program_selector, c.prog);
            check({tag, "_busy_e0"}, bus.busy, 1'b1);
         end else if (e == int'(SEL) - 1) begin
            check({tag, "_sel_last"}, bus.program_selector, c.prog);
         end else if (e == int'(SEL)) begin
            check({tag, "_sel_off"}, bus.program_selector, 0);
            check({tag, "_busy_wait"}, bus.busy, 1'b1);
         end else if (c.restart_at != 0 && e == c.restart_at + 1) begin
            check({tag, "_no_relaunch"}, bus.program_selector, 0);
         end
         if (e >= int'(SEL) && (bus.result_valid || bus.timed_out))
            done_seen = e;
         bus.start     = c.hold_start ? 1'b1 : (c.restart_at != 0 && n == c.restart_at);
         bus.core_data = data_at(c.kind, n, c.v);
      end
      check({tag, "_done_edge"}, done_seen, c.exp_done);
      check({tag, "_result"}, bus.result, c.exp_result);
      check({tag, "_valid"}, bus.result_valid, c.exp_valid);
      check({tag, "_timed_out"}, bus.timed_out, c.exp_tmo);
      check({tag, "_busy_done"}, bus.busy, 1'b0);
`ifdef PROG_LAUNCH_RUN_COUNT_EN
      check({tag, "_run_cycles"}, run_cycles, c.exp_done);
`endif
      if (c.hold_start) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check({tag, "_hold_valid"}, bus.result_valid, c.exp_valid);
            check({tag, "_hold_sel"}, bus.program_selector, 0);
            check({tag, "_hold_busy"}, bus.busy, 1'b0);
         end
      end
      bus.start = 1'b0;
      @(negedge clock);
      check({tag, "_clr_valid"}, bus.result_valid, 1'b0);
      check({tag, "_clr_tmo"}, bus.timed_out, 1'b0);
      check({tag, "_keep_result"}, bus.result, c.exp_result);
`ifdef PROG_LAUNCH_RUN_COUNT_EN
      check({tag, "_run_frozen"}, run_cycles, c.exp_done);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start     = 1'b0;
      bus.prog_id   = '0;
      bus.core_data = '0;

      //                prog          kind      v        rst hold done result  vld tmo
      tbl[0] = '{32'd1,        K_CONST,  32'h2A, 0, 1'b0, 10, 32'h2A, 1'b1, 1'b0};
      tbl[1] = '{32'd3,        K_STEPS,  32'h0,  0, 1'b0, 14, 32'd9,  1'b1, 1'b0};
      tbl[2] = '{32'hDEADBEEF, K_TOGGLE, 32'h0,  0, 1'b0, 66, 32'h5A, 1'b0, 1'b1};
      tbl[3] = '{32'd2,        K_HOLD,   32'd58, 0, 1'b0, 66, 32'h77, 1'b1, 1'b0};
      tbl[4] = '{32'd2,        K_HOLD,   32'd59, 0, 1'b0, 66, 32'h77, 1'b0, 1'b1};
      tbl[5] = '{32'd7,        K_CONST,  32'h11, 5, 1'b0, 10, 32'h11, 1'b1, 1'b0};
      tbl[6] = '{32'd9,        K_CONST,  32'h33, 0, 1'b1, 10, 32'h33, 1'b1, 1'b0};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_sel", bus.program_selector, 0);
      check("rst_result", bus.result, 0);
      check("rst_valid", bus.result_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_tmo", bus.timed_out, 1'b0);
      reset = 1'b1;
      @(negedge clock);

      foreach (tbl[i]) run_case(tbl[i], $sformatf("vec%0d", i));

      // Start with prog_id == 0 is ignored
      @(negedge clock);
      bus.prog_id = '0;
      bus.start   = 1'b1;
      @(negedge clock);
      check("zero_id_sel", bus.program_selector, 0);
      check("zero_id_busy", bus.busy, 1'b0);
      bus.start = 1'b0;
      @(negedge clock);
      check("zero_id_idle", bus.busy, 1'b0);

      // Reset asserted for one cycle while in ASSERT
      bus.prog_id   = 32'd5;
      bus.start     = 1'b1;
      bus.core_data = '0;
      @(negedge clock);
      check("mid_sel_on", bus.program_selector, 32'd5);
      check("mid_busy_on", bus.busy, 1'b1);
      reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge clock);
      check("mid_sel", bus.program_selector, 0);
      check("mid_busy", bus.busy, 1'b0);
      check("mid_valid", bus.result_valid, 1'b0);
      check("mid_tmo", bus.timed_out, 1'b0);
      check("mid_result", bus.result, 0);
      reset = 1'b1;
      @(negedge clock);
      check("mid_stay_idle", bus.busy, 1'b0);
      check("mid_stay_sel", bus.program_selector, 0);

      // Randomized launches against the reference model
      for (int r = 0; r < 8; r++) begin
         vec_t c;
         rnd_data[0] = $urandom;
         for (int n = 1; n <= MAXN; n++)
            rnd_data[n] = ($urandom_range(0, 6) == 0) ? $urandom : rnd_data[n-1];
         c.prog       = $urandom | 32'd1;
         c.kind       = K_RAND;
         c.v          = '0;
         c.restart_at = 0;
         c.hold_start = 1'b0;
         model(K_RAND, '0, c.exp_done, c.exp_result, c.exp_valid, c.exp_tmo);
         run_case(c, $sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
